// File: rtl/id_ex_stage_if.sv
// ID-side bundle delivered to the ID/EX pipeline register: decoded
// operands, register indices, immediate and control bits.
interface id_ex_stage_if;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_read_data1;
   logic [31:0] id_read_data2;
   logic [31:0] id_imm;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [4:0]  id_sa;
   logic [5:0]  id_funct;
   logic        id_reg_write;
   logic        id_mem_to_reg;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_branch;
   logic        id_alu_src;
   logic        id_reg_dst;
   logic        id_alu_op1;
   logic        id_alu_op2;

   // Decode stage drives the bundle.
   modport master (
      output id_pc_plus4, id_read_data1, id_read_data2, id_imm,
             id_rs, id_rt, id_rd, id_sa, id_funct,
             id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
             id_branch, id_alu_src, id_reg_dst, id_alu_op1, id_alu_op2
   );

   // ID/EX register consumes the bundle.
   modport slave (
      input  id_pc_plus4, id_read_data1, id_read_data2, id_imm,
             id_rs, id_rt, id_rd, id_sa, id_funct,
             id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
             id_branch, id_alu_src, id_reg_dst, id_alu_op1, id_alu_op2
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus the EX-side operand select: forwarding
// from EX/MEM and MEM/WB, ALU operand muxing, destination register and
// branch target. Update priority is reset > flush > hold > load; a
// bubble is all-zero, so it writes nothing and never forwards.
module id_ex_stage (
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   input  logic               flush,
   id_ex_stage_if.slave       id,
   input  logic               exm_reg_write,
   input  logic [4:0]         exm_rd,
   input  logic [31:0]        exm_result,
   input  logic               mwb_reg_write,
   input  logic [4:0]         mwb_rd,
   input  logic [31:0]        mwb_data,
   output logic [31:0]        ex_data1,
   output logic [31:0]        ex_data2,
   output logic [4:0]         ex_sa,
   output logic [5:0]         ex_funct,
   output logic               ex_alu_op1,
   output logic               ex_alu_op2,
   output logic [31:0]        ex_store_data,
   output logic [4:0]         ex_write_reg,
   output logic [31:0]        ex_branch_target,
   output logic               ex_reg_write,
   output logic               ex_mem_to_reg,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               ex_branch,
   output logic               ex_valid,
   output logic [1:0]         ex_fwd_a,
   output logic [1:0]         ex_fwd_b
);

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] read_data1;
      logic [31:0] read_data2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sa;
      logic [5:0]  funct;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;
      logic        reg_dst;
      logic        alu_op1;
      logic        alu_op2;
      logic        valid;
   } stage_t;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_MWB  = 2'b01;
   localparam logic [1:0] FWD_EXM  = 2'b10;

   stage_t      stage_q;
   stage_t      stage_d;
   logic [1:0]  fwd_a;
   logic [1:0]  fwd_b;
   logic [31:0] op_a;
   logic [31:0] op_b;

   // Next register contents: flush loads a bubble, hold keeps, else load.
   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d = '0;
      end else if (!hold) begin
         stage_d.pc_plus4   = id.id_pc_plus4;
         stage_d.read_data1 = id.id_read_data1;
         stage_d.read_data2 = id.id_read_data2;
         stage_d.imm        = id.id_imm;
         stage_d.rs         = id.id_rs;
         stage_d.rt         = id.id_rt;
         stage_d.rd         = id.id_rd;
         stage_d.sa         = id.id_sa;
         stage_d.funct      = id.id_funct;
         stage_d.reg_write  = id.id_reg_write;
         stage_d.mem_to_reg = id.id_mem_to_reg;
         stage_d.mem_read   = id.id_mem_read;
         stage_d.mem_write  = id.id_mem_write;
         stage_d.branch     = id.id_branch;
         stage_d.alu_src    = id.id_alu_src;
         stage_d.reg_dst    = id.id_reg_dst;
         stage_d.alu_op1    = id.id_alu_op1;
         stage_d.alu_op2    = id.id_alu_op2;
         stage_d.valid      = 1'b1;
      end
   end

   // Pipeline register with synchronous reset to a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Forwarding selects from stored rs/rt; EX/MEM beats MEM/WB, r0 never forwards.
   always_comb begin
      fwd_a = FWD_NONE;
      fwd_b = FWD_NONE;
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == stage_q.rs)) begin
         fwd_a = FWD_EXM;
      end else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == stage_q.rs)) begin
         fwd_a = FWD_MWB;
      end
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == stage_q.rt)) begin
         fwd_b = FWD_EXM;
      end else if (mwb_reg_write && (mwb_rd != 5'd0) && (mwb_rd == stage_q.rt)) begin
         fwd_b = FWD_MWB;
      end
   end

   // Forwarded rs/rt values.
   always_comb begin
      case (fwd_a)
         FWD_EXM: op_a = exm_result;
         FWD_MWB: op_a = mwb_data;
         default: op_a = stage_q.read_data1;
      endcase
      case (fwd_b)
         FWD_EXM: op_b = exm_result;
         FWD_MWB: op_b = mwb_data;
         default: op_b = stage_q.read_data2;
      endcase
   end

   assign ex_data1         = op_a;
   assign ex_data2         = stage_q.alu_src ? stage_q.imm : op_b;
   assign ex_store_data    = op_b;
   assign ex_write_reg     = stage_q.reg_dst ? stage_q.rd : stage_q.rt;
   assign ex_branch_target = stage_q.pc_plus4 + {stage_q.imm[29:0], 2'b00};
   assign ex_sa            = stage_q.sa;
   assign ex_funct         = stage_q.funct;
   assign ex_alu_op1       = stage_q.alu_op1;
   assign ex_alu_op2       = stage_q.alu_op2;
   assign ex_reg_write     = stage_q.reg_write;
   assign ex_mem_to_reg    = stage_q.mem_to_reg;
   assign ex_mem_read      = stage_q.mem_read;
   assign ex_mem_write     = stage_q.mem_write;
   assign ex_branch        = stage_q.branch;
   assign ex_valid         = stage_q.valid;
   assign ex_fwd_a         = fwd_a;
   assign ex_fwd_b         = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes hand-computed expected
// outputs into a queue; a monitor on the falling edge pops and compares.
module tb_id_ex_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  sa;
      logic [5:0]  funct;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;
      logic        reg_dst;
      logic        op1;
      logic        op2;
   } id_t;

   typedef struct packed {
      logic [31:0] data1;
      logic [31:0] data2;
      logic [31:0] store;
      logic [31:0] bt;
      logic [4:0]  wreg;
      logic [4:0]  sa;
      logic [5:0]  funct;
      logic        op1;
      logic        op2;
      logic        reg_write;
      logic        mem_to_reg;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        valid;
      logic [1:0]  fwd_a;
      logic [1:0]  fwd_b;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        hold;
   logic        flush;
   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        mwb_reg_write;
   logic [4:0]  mwb_rd;
   logic [31:0] mwb_data;
   logic [31:0] ex_data1, ex_data2, ex_store_data, ex_branch_target;
   logic [4:0]  ex_sa, ex_write_reg;
   logic [5:0]  ex_funct;
   logic        ex_alu_op1, ex_alu_op2, ex_reg_write, ex_mem_to_reg;
   logic        ex_mem_read, ex_mem_write, ex_branch, ex_valid;
   logic [1:0]  ex_fwd_a, ex_fwd_b;

   exp_t  exp_q[$];
   string lbl_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   id_ex_stage_if bus ();

   id_ex_stage dut (
      .clk              (clk),
      .reset            (reset),
      .hold             (hold),
      .flush            (flush),
      .id               (bus.slave),
      .exm_reg_write    (exm_reg_write),
      .exm_rd           (exm_rd),
      .exm_result       (exm_result),
      .mwb_reg_write    (mwb_reg_write),
      .mwb_rd           (mwb_rd),
      .mwb_data         (mwb_data),
      .ex_data1         (ex_data1),
      .ex_data2         (ex_data2),
      .ex_sa            (ex_sa),
      .ex_funct         (ex_funct),
      .ex_alu_op1       (ex_alu_op1),
      .ex_alu_op2       (ex_alu_op2),
      .ex_store_data    (ex_store_data),
      .ex_write_reg     (ex_write_reg),
      .ex_branch_target (ex_branch_target),
      .ex_reg_write     (ex_reg_write),
      .ex_mem_to_reg    (ex_mem_to_reg),
      .ex_mem_read      (ex_mem_read),
      .ex_mem_write     (ex_mem_write),
      .ex_branch        (ex_branch),
      .ex_valid         (ex_valid),
      .ex_fwd_a         (ex_fwd_a),
      .ex_fwd_b         (ex_fwd_b)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void cmp(input string lbl, input string fld,
                               input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s.%s actual=0x%08h expected=0x%08h", lbl, fld, act, exp);
      end else begin
         n_pass++;
      end
   endfunction

   // Monitor: compare DUT outputs against the oldest expectation.
   always @(negedge clk) begin
      exp_t  e;
      string l;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         l = lbl_q.pop_front();
         cmp(l, "data1",  ex_data1,         e.data1);
         cmp(l, "data2",  ex_data2,         e.data2);
         cmp(l, "store",  ex_store_data,    e.store);
         cmp(l, "btgt",   ex_branch_target, e.bt);
         cmp(l, "wreg",   32'(ex_write_reg), 32'(e.wreg));
         cmp(l, "sa",     32'(ex_sa),       32'(e.sa));
         cmp(l, "funct",  32'(ex_funct),    32'(e.funct));
         cmp(l, "ctrl",
             32'({ex_alu_op1, ex_alu_op2, ex_reg_write, ex_mem_to_reg,
                  ex_mem_read, ex_mem_write, ex_branch, ex_valid}),
             32'({e.op1, e.op2, e.reg_write, e.mem_to_reg,
                  e.mem_read, e.mem_write, e.branch, e.valid}));
         cmp(l, "fwd_a",  32'(ex_fwd_a),    32'(e.fwd_a));
         cmp(l, "fwd_b",  32'(ex_fwd_b),    32'(e.fwd_b));
      end
   end

   task automatic apply_id(input id_t v);
      bus.id_pc_plus4   = v.pc;
      bus.id_read_data1 = v.rd1;
      bus.id_read_data2 = v.rd2;
      bus.id_imm        = v.imm;
      bus.id_rs         = v.rs;
      bus.id_rt         = v.rt;
      bus.id_rd         = v.rd;
      bus.id_sa         = v.sa;
      bus.id_funct      = v.funct;
      bus.id_reg_write  = v.reg_write;
      bus.id_mem_to_reg = v.mem_to_reg;
      bus.id_mem_read   = v.mem_read;
      bus.id_mem_write  = v.mem_write;
      bus.id_branch     = v.branch;
      bus.id_alu_src    = v.alu_src;
      bus.id_reg_dst    = v.reg_dst;
      bus.id_alu_op1    = v.op1;
      bus.id_alu_op2    = v.op2;
   endtask

   function automatic id_t rand_id();
      id_t v;
      v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return v;
   endfunction

   // Pass-through fields of a loaded instruction; operand/target fields set by caller.
   function automatic exp_t loaded(input id_t v);
      exp_t e;
      e = '0;
      e.sa = v.sa; e.funct = v.funct; e.op1 = v.op1; e.op2 = v.op2;
      e.reg_write = v.reg_write; e.mem_to_reg = v.mem_to_reg;
      e.mem_read = v.mem_read; e.mem_write = v.mem_write;
      e.branch = v.branch; e.valid = 1'b1;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string lbl, input exp_t e);
      exp_q.push_back(e);
      lbl_q.push_back(lbl);
      @(negedge clk);
      #1;
   endtask

   task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                          input logic mw, input logic [4:0] mr, input logic [31:0] mv);
      exm_reg_write = ew; exm_rd = er; exm_result = ev;
      mwb_reg_write = mw; mwb_rd = mr; mwb_data = mv;
   endtask

   // Directed stimulus
   initial begin
      id_t  a;
      id_t  v;
      exp_t e;
      reset = 1'b1; hold = 1'b0; flush = 1'b0;
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      apply_id(rand_id());

      // Reset with random id_* for two cycles
      for (int i = 0; i < 2; i++) begin
         apply_id(rand_id());
         step();
         expect_now($sformatf("reset%0d", i), '0);
      end
      reset = 1'b0;

      // Pass-through
      v = '0;
      v.pc = 32'h0000_1000; v.rd1 = 32'h11; v.rd2 = 32'h22; v.imm = 32'h10;
      v.rs = 5'd3; v.rt = 5'd4; v.rd = 5'd5; v.sa = 5'd9; v.funct = 6'h20;
      v.reg_write = 1'b1; v.reg_dst = 1'b1; v.op1 = 1'b1;
      apply_id(v);
      step();
      e = loaded(v);
      e.data1 = 32'h11; e.data2 = 32'h22; e.store = 32'h22;
      e.wreg = 5'd5; e.bt = 32'h0000_1040;
      expect_now("pass", e);

      // Forward priority on rs, then MEM/WB on rt
      v = '0;
      v.pc = 32'h0000_0200; v.rd1 = 32'h1; v.rd2 = 32'h2; v.imm = 32'h0;
      v.rs = 5'd7; v.rt = 5'd8; v.rd = 5'd9; v.reg_write = 1'b1; v.reg_dst = 1'b1;
      v.op2 = 1'b1; v.funct = 6'h22;
      apply_id(v);
      step();
      set_fwd(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'hBBBB);
      e = loaded(v);
      e.data1 = 32'hAAAA; e.data2 = 32'h2; e.store = 32'h2; e.wreg = 5'd9;
      e.bt = 32'h0000_0200; e.fwd_a = 2'b10;
      expect_now("fwd_exm", e);
      exm_reg_write = 1'b0;
      e.data1 = 32'hBBBB; e.fwd_a = 2'b01;
      expect_now("fwd_mwb", e);
      set_fwd(1'b1, 5'd3, 32'hCCCC, 1'b1, 5'd8, 32'hDDDD);
      e.data1 = 32'h1; e.fwd_a = 2'b00;
      e.data2 = 32'hDDDD; e.store = 32'hDDDD; e.fwd_b = 2'b01;
      expect_now("fwd_b_mwb", e);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Register 0 never forwards
      v = '0;
      v.pc = 32'h0000_0040; v.rd1 = 32'h5; v.rd2 = 32'h33;
      v.rs = 5'd0; v.rt = 5'd0; v.rd = 5'd2; v.reg_dst = 1'b1; v.reg_write = 1'b1;
      apply_id(v);
      step();
      set_fwd(1'b1, 5'd0, 32'hEEEE, 1'b1, 5'd0, 32'hFFFF);
      e = loaded(v);
      e.data1 = 32'h5; e.data2 = 32'h33; e.store = 32'h33; e.wreg = 5'd2;
      e.bt = 32'h0000_0040;
      expect_now("r0_nofwd", e);
      v.rd2 = 32'h44; v.alu_src = 1'b1; v.imm = 32'hFFFF_FFFC; v.reg_dst = 1'b0;
      v.mem_read = 1'b1; v.mem_to_reg = 1'b1;
      apply_id(v);
      step();
      e = loaded(v);
      e.data1 = 32'h5; e.data2 = 32'hFFFF_FFFC; e.store = 32'h44; e.wreg = 5'd0;
      e.bt = 32'h0000_0030;
      expect_now("r0_imm", e);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Hold 3 cycles with changing id_*, forwarding still live, then flush+hold
      a = '0;
      a.pc = 32'h0000_2000; a.rd1 = 32'h55; a.rd2 = 32'h66; a.imm = 32'h4;
      a.rs = 5'd9; a.rt = 5'd10; a.rd = 5'd11; a.sa = 5'd3; a.funct = 6'h2A;
      a.reg_write = 1'b1; a.mem_write = 1'b1; a.alu_src = 1'b1; a.branch = 1'b1;
      apply_id(a);
      step();
      e = loaded(a);
      e.data1 = 32'h55; e.data2 = 32'h4; e.store = 32'h66; e.wreg = 5'd10;
      e.bt = 32'h0000_2010;
      expect_now("hold_load", e);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_id(rand_id());
         step();
         if (i == 1) begin
            set_fwd(1'b1, 5'd9, 32'h77, 1'b1, 5'd10, 32'h88);
            e.data1 = 32'h77; e.fwd_a = 2'b10; e.store = 32'h88; e.fwd_b = 2'b01;
         end
         expect_now($sformatf("hold%0d", i), e);
      end
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      flush = 1'b1;
      step();
      expect_now("flush_hold", '0);
      flush = 1'b0; hold = 1'b0;

      // Reset mid-hold discards the held instruction
      apply_id(a);
      step();
      hold = 1'b1;
      apply_id(rand_id());
      reset = 1'b1;
      step();
      expect_now("reset_hold", '0);
      reset = 1'b0; hold = 1'b0;

      // Branch targets, including 32-bit wrap
      v = '0;
      v.pc = 32'h0000_0100; v.imm = 32'hFFFF_FFFF; v.rs = 5'd1; v.rt = 5'd2;
      v.rd1 = 32'h9; v.rd2 = 32'hA; v.branch = 1'b1;
      apply_id(v);
      step();
      e = loaded(v);
      e.data1 = 32'h9; e.data2 = 32'hA; e.store = 32'hA; e.wreg = 5'd2;
      e.bt = 32'h0000_00FC;
      expect_now("btgt_neg", e);
      v.pc = 32'hFFFF_FFFC; v.imm = 32'h2;
      apply_id(v);
      step();
      e.bt = 32'h0000_0004;
      expect_now("btgt_wrap", e);

      // Flush alone
      flush = 1'b1;
      step();
      expect_now("flush", '0);
      flush = 1'b0;

      step();
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
      end else begin
         n_pass++;
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
